// File: rtl/cond_exmem_stage.sv
// Execute-stage condition check fused with the E->M pipeline register.
// Owns the architectural NZCV flags and gates E-stage side effects on the condition result.
module cond_exmem_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enM,
   input  logic              flushM,
   input  logic              PCSrcE,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   input  logic              BranchE,
   input  logic              BrlE,
   input  logic [1:0]        FlagWriteE,
   input  logic [3:0]        CondE,
   input  logic [3:0]        ALUFlags,
   input  logic [DATA_W-1:0] ALUResultE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [ADDR_W-1:0] WA3E,
   output logic [3:0]        Flags,
   output logic              CondExE,
   output logic              BranchTakenE,
   output logic              PCSrcM,
   output logic              RegWriteM,
   output logic              MemtoRegM,
   output logic              MemWriteM,
   output logic              BrlM,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [ADDR_W-1:0] WA3M
);

   logic [3:0]        r_flags;
   logic              r_pcSrcM;
   logic              r_regWriteM;
   logic              r_memtoRegM;
   logic              r_memWriteM;
   logic              r_brlM;
   logic [DATA_W-1:0] r_aluOutM;
   logic [DATA_W-1:0] r_writeDataM;
   logic [ADDR_W-1:0] r_wa3M;

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;
   logic w_condEx;
   logic w_load;

   assign {w_n, w_z, w_c, w_v} = r_flags;

   // Condition is evaluated against the committed flags, never the ALU's in-flight flags.
   always_comb begin
      w_condEx = 1'b1;
      case (CondE)
         4'b0000: w_condEx = w_z;
         4'b0001: w_condEx = ~w_z;
         4'b0010: w_condEx = w_c;
         4'b0011: w_condEx = ~w_c;
         4'b0100: w_condEx = w_n;
         4'b0101: w_condEx = ~w_n;
         4'b0110: w_condEx = w_v;
         4'b0111: w_condEx = ~w_v;
         4'b1000: w_condEx = w_c & ~w_z;
         4'b1001: w_condEx = ~w_c | w_z;
         4'b1010: w_condEx = (w_n == w_v);
         4'b1011: w_condEx = (w_n != w_v);
         4'b1100: w_condEx = ~w_z & (w_n == w_v);
         4'b1101: w_condEx = w_z | (w_n != w_v);
         default: w_condEx = 1'b1;
      endcase
   end

   assign w_load = enM & ~flushM;

   // Flush wins over stall so the hazard unit can bubble M while E is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcSrcM     <= 1'b0;
         r_regWriteM  <= 1'b0;
         r_memtoRegM  <= 1'b0;
         r_memWriteM  <= 1'b0;
         r_brlM       <= 1'b0;
         r_aluOutM    <= '0;
         r_writeDataM <= '0;
         r_wa3M       <= '0;
      end else if (flushM) begin
         r_pcSrcM     <= 1'b0;
         r_regWriteM  <= 1'b0;
         r_memtoRegM  <= 1'b0;
         r_memWriteM  <= 1'b0;
         r_brlM       <= 1'b0;
         r_aluOutM    <= '0;
         r_writeDataM <= '0;
         r_wa3M       <= '0;
      end else if (enM) begin
         r_pcSrcM     <= PCSrcE & w_condEx;
         r_regWriteM  <= RegWriteE & w_condEx;
         r_memtoRegM  <= MemtoRegE;
         r_memWriteM  <= MemWriteE & w_condEx;
         r_brlM       <= BrlE & w_condEx;
         r_aluOutM    <= ALUResultE;
         r_writeDataM <= WriteDataE;
         r_wa3M       <= WA3E;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= 4'b0000;
      end else if (w_load && w_condEx) begin
         if (FlagWriteE[1]) r_flags[3:2] <= ALUFlags[3:2];
         if (FlagWriteE[0]) r_flags[1:0] <= ALUFlags[1:0];
      end
   end

   assign Flags        = r_flags;
   assign CondExE      = w_condEx;
   assign BranchTakenE = BranchE & w_condEx;
   assign PCSrcM       = r_pcSrcM;
   assign RegWriteM    = r_regWriteM;
   assign MemtoRegM    = r_memtoRegM;
   assign MemWriteM    = r_memWriteM;
   assign BrlM         = r_brlM;
   assign ALUOutM      = r_aluOutM;
   assign WriteDataM   = r_writeDataM;
   assign WA3M         = r_wa3M;

endmodule

// File: tb/tb_cond_exmem_stage.sv
// Scoreboard bench for cond_exmem_stage: directed scenarios plus random traffic
// checked against an ARM-condition reference model.
module tb_cond_exmem_stage;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef struct packed {
      logic              en;
      logic              flush;
      logic              pcSrc;
      logic              regWrite;
      logic              memtoReg;
      logic              memWrite;
      logic              branch;
      logic              brl;
      logic [1:0]        flagWrite;
      logic [3:0]        cond;
      logic [3:0]        aluFlags;
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] writeData;
      logic [ADDR_W-1:0] wa3;
   } stim_t;

   typedef struct packed {
      logic              pcSrc;
      logic              regWrite;
      logic              memtoReg;
      logic              memWrite;
      logic              brl;
      logic [DATA_W-1:0] aluOut;
      logic [DATA_W-1:0] writeData;
      logic [ADDR_W-1:0] wa3;
   } mstate_t;

   typedef struct packed {
      logic [3:0] flags;
      mstate_t    m;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enM = 1'b0;
   logic              flushM = 1'b0;
   logic              PCSrcE = 1'b0;
   logic              RegWriteE = 1'b0;
   logic              MemtoRegE = 1'b0;
   logic              MemWriteE = 1'b0;
   logic              BranchE = 1'b0;
   logic              BrlE = 1'b0;
   logic [1:0]        FlagWriteE = '0;
   logic [3:0]        CondE = '0;
   logic [3:0]        ALUFlags = '0;
   logic [DATA_W-1:0] ALUResultE = '0;
   logic [DATA_W-1:0] WriteDataE = '0;
   logic [ADDR_W-1:0] WA3E = '0;
   logic [3:0]        Flags;
   logic              CondExE;
   logic              BranchTakenE;
   logic              PCSrcM;
   logic              RegWriteM;
   logic              MemtoRegM;
   logic              MemWriteM;
   logic              BrlM;
   logic [DATA_W-1:0] ALUOutM;
   logic [DATA_W-1:0] WriteDataM;
   logic [ADDR_W-1:0] WA3M;

   int checks = 0;
   int errors = 0;

   exp_t    sbq[$];
   logic [3:0] modelFlags = '0;
   mstate_t modelM = '0;

   cond_exmem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .enM(enM), .flushM(flushM),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .MemWriteE(MemWriteE), .BranchE(BranchE), .BrlE(BrlE),
      .FlagWriteE(FlagWriteE), .CondE(CondE), .ALUFlags(ALUFlags),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
      .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
      .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM), .BrlM(BrlM), .ALUOutM(ALUOutM),
      .WriteDataM(WriteDataM), .WA3M(WA3M)
   );

   always #5 clk = ~clk;

   // ARM rule: odd codes are the negation of the even code below them; 111x always executes.
   function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
      logic n;
      logic z;
      logic c;
      logic v;
      logic base;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: return 1'b1;
      endcase
      return cond[0] ? !base : base;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      logic pass;
      @(negedge clk);
      enM        = s.en;
      flushM     = s.flush;
      PCSrcE     = s.pcSrc;
      RegWriteE  = s.regWrite;
      MemtoRegE  = s.memtoReg;
      MemWriteE  = s.memWrite;
      BranchE    = s.branch;
      BrlE       = s.brl;
      FlagWriteE = s.flagWrite;
      CondE      = s.cond;
      ALUFlags   = s.aluFlags;
      ALUResultE = s.result;
      WriteDataE = s.writeData;
      WA3E       = s.wa3;
      #1;
      pass = condPass(s.cond, modelFlags);
      checkOutput("CondExE", 64'(CondExE), 64'(pass));
      checkOutput("BranchTakenE", 64'(BranchTakenE), 64'(s.branch && pass));
      if (s.flush) begin
         modelM = '0;
      end else if (s.en) begin
         modelM.pcSrc     = s.pcSrc && pass;
         modelM.regWrite  = s.regWrite && pass;
         modelM.memtoReg  = s.memtoReg;
         modelM.memWrite  = s.memWrite && pass;
         modelM.brl       = s.brl && pass;
         modelM.aluOut    = s.result;
         modelM.writeData = s.writeData;
         modelM.wa3       = s.wa3;
         if (pass) begin
            modelFlags = {s.flagWrite[1] ? s.aluFlags[3:2] : modelFlags[3:2],
                          s.flagWrite[0] ? s.aluFlags[1:0] : modelFlags[1:0]};
         end
      end
      sbq.push_back('{flags: modelFlags, m: modelM});
   endtask

   function automatic stim_t randomStim();
      stim_t s;
      s.en        = ($urandom_range(0, 3) != 0);
      s.flush     = ($urandom_range(0, 7) == 0);
      s.pcSrc     = 1'($urandom);
      s.regWrite  = 1'($urandom);
      s.memtoReg  = 1'($urandom);
      s.memWrite  = 1'($urandom);
      s.branch    = 1'($urandom);
      s.brl       = 1'($urandom);
      s.flagWrite = 2'($urandom);
      s.cond      = 4'($urandom);
      s.aluFlags  = 4'($urandom);
      s.result    = DATA_W'($urandom);
      s.writeData = DATA_W'($urandom);
      s.wa3       = ADDR_W'($urandom);
      return s;
   endfunction

   function automatic stim_t flagSet(input logic [3:0] f);
      stim_t s;
      s = '0;
      s.en = 1'b1;
      s.cond = 4'b1110;
      s.flagWrite = 2'b11;
      s.aluFlags = f;
      return s;
   endfunction

   // Random inputs are driven while reset is asserted; outputs must clear before the next edge.
   task automatic resetCheck();
      stim_t r;
      @(negedge clk);
      r = randomStim();
      enM = 1'b1;
      flushM = 1'b0;
      RegWriteE = r.regWrite;
      MemtoRegE = r.memtoReg;
      CondE = r.cond;
      FlagWriteE = r.flagWrite;
      ALUFlags = r.aluFlags;
      ALUResultE = r.result;
      WA3E = r.wa3;
      #2 reset = 1'b0;
      #1;
      checkOutput("reset_Flags", 64'(Flags), 64'd0);
      checkOutput("reset_ctrlM", 64'({PCSrcM, RegWriteM, MemtoRegM, MemWriteM, BrlM}), 64'd0);
      checkOutput("reset_dataM", 64'({ALUOutM, WriteDataM, WA3M}), 64'd0);
      modelFlags = '0;
      modelM = '0;
      @(negedge clk);
      enM = 1'b0;
      flushM = 1'b1;
      reset = 1'b1;
   endtask

   task automatic afterEdge();
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("Flags", 64'(Flags), 64'(e.flags));
            checkOutput("PCSrcM", 64'(PCSrcM), 64'(e.m.pcSrc));
            checkOutput("RegWriteM", 64'(RegWriteM), 64'(e.m.regWrite));
            checkOutput("MemtoRegM", 64'(MemtoRegM), 64'(e.m.memtoReg));
            checkOutput("MemWriteM", 64'(MemWriteM), 64'(e.m.memWrite));
            checkOutput("BrlM", 64'(BrlM), 64'(e.m.brl));
            checkOutput("ALUOutM", 64'(ALUOutM), 64'(e.m.aluOut));
            checkOutput("WriteDataM", 64'(WriteDataM), 64'(e.m.writeData));
            checkOutput("WA3M", 64'(WA3M), 64'(e.m.wa3));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : driver
      stim_t s;
      resetCheck();

      applyStimulus(flagSet(4'b0100));
      afterEdge();
      checkOutput("tp_flagSet", 64'(Flags), 64'b0100);
      s = '0; s.en = 1'b1; s.cond = 4'b0000; s.regWrite = 1'b1; s.wa3 = 4'd5; s.result = 32'h0000_002A;
      applyStimulus(s);
      afterEdge();
      checkOutput("tp_eq_RegWriteM", 64'(RegWriteM), 64'd1);
      checkOutput("tp_eq_WA3M", 64'(WA3M), 64'd5);
      checkOutput("tp_eq_ALUOutM", 64'(ALUOutM), 64'h2A);
      s.cond = 4'b0001;
      applyStimulus(s);
      afterEdge();
      checkOutput("tp_ne_RegWriteM", 64'(RegWriteM), 64'd0);

      applyStimulus(flagSet(4'b1111));
      s = flagSet(4'b0000); s.flagWrite = 2'b10;
      applyStimulus(s);
      afterEdge();
      checkOutput("tp_partial_NZ", 64'(Flags), 64'b0011);
      s.flagWrite = 2'b01;
      applyStimulus(s);
      afterEdge();
      checkOutput("tp_partial_CV", 64'(Flags), 64'b0000);

      s = flagSet(4'b1111); s.cond = 4'b0000; s.memWrite = 1'b1; s.branch = 1'b1;
      applyStimulus(s);
      checkOutput("tp_suppress_BranchTaken", 64'(BranchTakenE), 64'd0);
      afterEdge();
      checkOutput("tp_suppress_MemWriteM", 64'(MemWriteM), 64'd0);
      checkOutput("tp_suppress_Flags", 64'(Flags), 64'b0000);

      s = flagSet(4'b0110); s.regWrite = 1'b1; s.wa3 = 4'd3;
      applyStimulus(s);
      for (int i = 0; i < 3; i++) begin
         s = randomStim(); s.en = 1'b0; s.flush = 1'b0; s.wa3 = 4'd9;
         applyStimulus(s);
         afterEdge();
         checkOutput("tp_stall_WA3M", 64'(WA3M), 64'd3);
         checkOutput("tp_stall_RegWriteM", 64'(RegWriteM), 64'd1);
      end
      s = randomStim(); s.en = 1'b0; s.flush = 1'b1;
      applyStimulus(s);
      afterEdge();
      checkOutput("tp_flush_ctrl", 64'({PCSrcM, RegWriteM, MemtoRegM, MemWriteM, BrlM}), 64'd0);
      checkOutput("tp_flush_data", 64'({ALUOutM, WriteDataM, WA3M}), 64'd0);
      checkOutput("tp_flush_Flags", 64'(Flags), 64'b0110);

      s = '0; s.cond = 4'b1000;
      applyStimulus(s);
      checkOutput("tp_HI", 64'(CondExE), 64'd0);
      s.cond = 4'b1001;
      applyStimulus(s);
      checkOutput("tp_LS", 64'(CondExE), 64'd1);

      applyStimulus(flagSet(4'b1001));
      s = '0; s.cond = 4'b1010; applyStimulus(s); checkOutput("tp_GE_nv", 64'(CondExE), 64'd1);
      s.cond = 4'b1011; applyStimulus(s); checkOutput("tp_LT_nv", 64'(CondExE), 64'd0);
      s.cond = 4'b1100; applyStimulus(s); checkOutput("tp_GT_nv", 64'(CondExE), 64'd1);
      s.cond = 4'b1101; applyStimulus(s); checkOutput("tp_LE_nv", 64'(CondExE), 64'd0);
      applyStimulus(flagSet(4'b1000));
      s = '0; s.cond = 4'b1010; applyStimulus(s); checkOutput("tp_GE_n", 64'(CondExE), 64'd0);
      s.cond = 4'b1011; applyStimulus(s); checkOutput("tp_LT_n", 64'(CondExE), 64'd1);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(randomStim());
         if (i == 300) begin
            afterEdge();
            resetCheck();
         end
      end

      for (int i = 0; i < 10 && sbq.size() > 0; i++) afterEdge();
      if (sbq.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expected responses left, required 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
